// File: rtl/btn_sw_conditioner_pkg.sv
// Shared definitions for the board input-conditioning front end:
// button indices, default timing and the debounce FSM state encoding.
package fpsr_pkg;

  localparam int NUM_BTN = 5;
  localparam int NUM_SW  = 4;

  // Bit positions of the buttons inside the Btn_* buses
  localparam int BTN_C = 0;
  localparam int BTN_L = 1;
  localparam int BTN_R = 2;
  localparam int BTN_U = 3;
  localparam int BTN_D = 4;

  // Timing at the 100 MHz board clock: 10 ms debounce, 250 ms auto-repeat
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_REPEAT_CYCLES   = 25_000_000;

  // One-hot debounce FSM states
  typedef enum logic [5:0] {
    ST_IDLE   = 6'b000001,
    ST_ARM    = 6'b000010,
    ST_PULSE  = 6'b000100,
    ST_HOLD   = 6'b001000,
    ST_REPEAT = 6'b010000,
    ST_REL    = 6'b100000
  } deb_state_e;

  // Counter width able to hold max(a, b) - 1, never narrower than one bit
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/btn_sw_conditioner_if.sv
// Pin-side and FSM-side signals of the input conditioner, grouped so the
// board wrapper and the conditioner connect through a single port.
interface btn_sw_conditioner_if
  import fpsr_pkg::*;
#(
  parameter int N_BTN = NUM_BTN,
  parameter int N_SW  = NUM_SW
);

  logic [N_BTN-1:0] Btn_raw;
  logic [N_SW-1:0]  Sw_raw;
  logic [N_BTN-1:0] Btn_DPB;
  logic [N_BTN-1:0] Btn_SCEN;
  logic [N_BTN-1:0] Btn_MCEN;
  logic [N_SW-1:0]  Sw_sync;
  logic             Any_SCEN;

  // Board side: drives the raw pins and consumes the conditioned outputs
  modport master (
    output Btn_raw, Sw_raw,
    input  Btn_DPB, Btn_SCEN, Btn_MCEN, Sw_sync, Any_SCEN
  );

  // Conditioner side
  modport slave (
    input  Btn_raw, Sw_raw,
    output Btn_DPB, Btn_SCEN, Btn_MCEN, Sw_sync, Any_SCEN
  );

endinterface

// File: rtl/btn_sw_conditioner_debounce.sv
// One push-button channel: two-flop synchroniser, debounce FSM with a single
// shared counter, and Moore-decoded level / single / multi pulse outputs.
module btn_debounce
  import fpsr_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_raw,
  output logic o_dpb,
  output logic o_scen,
  output logic o_mcen
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_CYCLES);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          w_s;
  deb_state_e    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_dpb;
  logic          r_scen;
  logic          r_mcen;

  assign w_s = r_sync2;

  // Bring the asynchronous pin into the clock domain
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce/repeat FSM; outputs are registered alongside the state they decode
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_dpb   <= 1'b0;
      r_scen  <= 1'b0;
      r_mcen  <= 1'b0;
    end else begin
      r_scen <= 1'b0;
      r_mcen <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_s) begin
            r_state <= ST_ARM;
            r_cnt   <= '0;
          end
        end
        ST_ARM: begin
          if (!w_s) begin
            r_state <= ST_IDLE;
          end else if (r_cnt == DEB_LAST) begin
            r_state <= ST_PULSE;
            r_dpb   <= 1'b1;
            r_scen  <= 1'b1;
            r_mcen  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_PULSE, ST_REPEAT: begin
          r_state <= ST_HOLD;
          r_cnt   <= '0;
        end
        ST_HOLD: begin
          if (!w_s) begin
            r_state <= ST_REL;
            r_cnt   <= '0;
          end else if (r_cnt == REP_LAST) begin
            r_state <= ST_REPEAT;
            r_mcen  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_REL: begin
          if (w_s) begin
            r_state <= ST_HOLD;
            r_cnt   <= '0;
          end else if (r_cnt == DEB_LAST) begin
            r_state <= ST_IDLE;
            r_dpb   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_dpb   <= 1'b0;
        end
      endcase
    end
  end

  assign o_dpb  = r_dpb;
  assign o_scen = r_scen;
  assign o_mcen = r_mcen;

endmodule

// File: rtl/btn_sw_conditioner.sv
// Input-conditioning front end between the board pins and the game FSM:
// debounced buttons with press/repeat pulses and synchronised switches.
module btn_sw_conditioner
  import fpsr_pkg::*;
#(
  parameter int N_BTN           = NUM_BTN,
  parameter int N_SW            = NUM_SW,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic                  Clk,
  input  logic                  Reset,
  btn_sw_conditioner_if.slave   bus
);

  logic [N_BTN-1:0] w_dpb;
  logic [N_BTN-1:0] w_scen;
  logic [N_BTN-1:0] w_mcen;
  logic [N_SW-1:0]  r_sw1;
  logic [N_SW-1:0]  r_sw2;

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_deb (
      .i_clk     (Clk),
      .i_rst_n   (Reset),
      .i_btn_raw (bus.Btn_raw[g]),
      .o_dpb     (w_dpb[g]),
      .o_scen    (w_scen[g]),
      .o_mcen    (w_mcen[g])
    );
  end

  // Switches only need metastability protection; they are not debounced
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_sw1 <= '0;
      r_sw2 <= '0;
    end else begin
      r_sw1 <= bus.Sw_raw;
      r_sw2 <= r_sw1;
    end
  end

  assign bus.Btn_DPB  = w_dpb;
  assign bus.Btn_SCEN = w_scen;
  assign bus.Btn_MCEN = w_mcen;
  assign bus.Sw_sync  = r_sw2;
  assign bus.Any_SCEN = |w_scen;

endmodule

// File: tb/tb_btn_sw_conditioner.sv
// Self-checking bench for btn_sw_conditioner with short debounce/repeat times.
// A behavioural model tracks, per button, how many consecutive synchronised
// samples agree with a change of level and how long the button has been held,
// and predicts every output each cycle; directed phases add timing checks.
module tb_btn_sw_conditioner;
  import fpsr_pkg::*;

  localparam int D = 4;
  localparam int R = 8;

  logic Clk;
  logic Reset;

  btn_sw_conditioner_if #(.N_BTN(5), .N_SW(4)) bus ();

  btn_sw_conditioner #(
    .N_BTN           (5),
    .N_SW            (4),
    .DEBOUNCE_CYCLES (D),
    .REPEAT_CYCLES   (R)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;
  int edgeNo = 0;

  // Reference model state
  logic [4:0] mS1, mS2;
  logic [3:0] mW1, mW2;
  bit mLvl [5];
  bit mBlind [5];
  bit mScen [5];
  bit mMcen [5];
  int mStreak [5];
  int mAge [5];

  // Observed-event statistics for the directed timing checks
  int scenCnt [5];
  int scenFirst [5];
  int mcenCnt [5];
  int mcenAt [5][8];
  int dpbRise [5];
  int dpbFall [5];
  bit dpbSeen [5];
  int anyCnt;
  int anyFirst;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s edge=%0d observed=%0h expected=%0h", tag, edgeNo, obs, exp);
    end
  endtask

  task automatic modelReset();
    mS1 = '0; mS2 = '0; mW1 = '0; mW2 = '0;
    for (int b = 0; b < 5; b++) begin
      mLvl[b] = 0; mBlind[b] = 0; mScen[b] = 0; mMcen[b] = 0;
      mStreak[b] = 0; mAge[b] = 0;
    end
  endtask

  // Sample taken in a pulse cycle is ignored; otherwise D+1 agreeing samples
  // change the level, and R held samples in a row give a repeat pulse.
  task automatic modelStep();
    logic [4:0] s;
    if (!Reset) begin
      modelReset();
    end else begin
      s = mS2;
      mS2 = mS1; mS1 = bus.Btn_raw;
      mW2 = mW1; mW1 = bus.Sw_raw;
      for (int b = 0; b < 5; b++) begin
        mScen[b] = 0; mMcen[b] = 0;
        if (mBlind[b]) begin
          mBlind[b] = 0; mStreak[b] = 0; mAge[b] = 0;
        end else if (!mLvl[b]) begin
          mStreak[b] = s[b] ? mStreak[b] + 1 : 0;
          if (mStreak[b] == D + 1) begin
            mLvl[b] = 1; mScen[b] = 1; mMcen[b] = 1; mBlind[b] = 1; mStreak[b] = 0;
          end
        end else if (!s[b]) begin
          mStreak[b]++; mAge[b] = 0;
          if (mStreak[b] == D + 1) begin
            mLvl[b] = 0; mStreak[b] = 0;
          end
        end else if (mStreak[b] > 0) begin
          mStreak[b] = 0; mAge[b] = 0;
        end else begin
          mAge[b]++;
          if (mAge[b] == R) begin
            mMcen[b] = 1; mBlind[b] = 1;
          end
        end
      end
    end
  endtask

  task automatic resetStats();
    for (int b = 0; b < 5; b++) begin
      scenCnt[b] = 0; scenFirst[b] = -1; mcenCnt[b] = 0;
      dpbRise[b] = -1; dpbFall[b] = -1; dpbSeen[b] = 0;
      for (int i = 0; i < 8; i++) mcenAt[b][i] = -1;
    end
    anyCnt = 0; anyFirst = -1;
  endtask

  task automatic checkOutput();
    logic [4:0] eD, eS, eM;
    for (int b = 0; b < 5; b++) begin
      eD[b] = mLvl[b]; eS[b] = mScen[b]; eM[b] = mMcen[b];
    end
    checkEq("dpb", 32'(bus.Btn_DPB), 32'(eD));
    checkEq("scen", 32'(bus.Btn_SCEN), 32'(eS));
    checkEq("mcen", 32'(bus.Btn_MCEN), 32'(eM));
    checkEq("sw_sync", 32'(bus.Sw_sync), 32'(mW2));
    checkEq("any_scen", 32'(bus.Any_SCEN), 32'(|eS));
    for (int b = 0; b < 5; b++) begin
      if (bus.Btn_SCEN[b]) begin
        if (scenCnt[b] == 0) scenFirst[b] = edgeNo;
        scenCnt[b]++;
      end
      if (bus.Btn_MCEN[b]) begin
        if (mcenCnt[b] < 8) mcenAt[b][mcenCnt[b]] = edgeNo;
        mcenCnt[b]++;
      end
      if (bus.Btn_DPB[b]) begin
        if (!dpbSeen[b]) dpbRise[b] = edgeNo;
        dpbSeen[b] = 1;
      end else if (dpbSeen[b] && dpbFall[b] < 0) begin
        dpbFall[b] = edgeNo;
      end
    end
    if (bus.Any_SCEN) begin
      if (anyCnt == 0) anyFirst = edgeNo;
      anyCnt++;
    end
  endtask

  // Drive one cycle of pins, advance the model on the edge, check at negedge
  task automatic applyStimulus(input logic [4:0] btn, input logic [3:0] sw);
    bus.Btn_raw = btn;
    bus.Sw_raw  = sw;
    @(posedge Clk);
    edgeNo++;
    modelStep();
    @(negedge Clk);
    checkOutput();
  endtask

  // Directed phases followed by a randomized soak, all in one linear sequence
  initial begin
    int p;
    int g;
    logic [4:0] cur;
    logic [3:0] swCur;

    Reset = 1'b0;
    bus.Btn_raw = '0;
    bus.Sw_raw  = '0;
    modelReset();
    resetStats();

    #2;
    checkEq("reset_dpb", 32'(bus.Btn_DPB), 0);
    checkEq("reset_scen", 32'(bus.Btn_SCEN), 0);
    checkEq("reset_mcen", 32'(bus.Btn_MCEN), 0);
    checkEq("reset_sw", 32'(bus.Sw_sync), 0);
    checkEq("reset_any", 32'(bus.Any_SCEN), 0);
    applyStimulus(5'b0, 4'b0);
    applyStimulus(5'b0, 4'b0);
    Reset = 1'b1;
    edgeNo = 0;
    resetStats();

    // Switch sync at edge 5 and clean BtnC press sampled from edge 10 to 49
    $display("[TB] phase: switch sync and clean press");
    for (int e = 1; e <= 60; e++) begin
      applyStimulus((e >= 10 && e <= 49) ? 5'b00001 : 5'b0, (e >= 5) ? 4'b1010 : 4'b0);
      if (e == 5) checkEq("sw_not_yet", 32'(bus.Sw_sync), 0);
      if (e == 6) checkEq("sw_after_two_edges", 32'(bus.Sw_sync), 32'b1010);
    end
    checkEq("clean_scen_count", scenCnt[BTN_C], 1);
    checkEq("clean_scen_edge", scenFirst[BTN_C], 10 + D + 2);
    checkEq("clean_dpb_rise", dpbRise[BTN_C], 10 + D + 2);
    // Pulse cycle plus R held cycles separate successive MCEN pulses
    checkEq("clean_first_repeat", mcenAt[BTN_C][1], 10 + D + 2 + R + 1);
    checkEq("clean_second_repeat", mcenAt[BTN_C][2], 10 + D + 2 + 2 * (R + 1));
    checkEq("clean_mcen_count", mcenCnt[BTN_C], 4);
    checkEq("clean_dpb_fall", dpbFall[BTN_C], 50 + D + 2);
    checkEq("clean_others_quiet", scenCnt[1] + scenCnt[2] + scenCnt[3] + scenCnt[4]
            + mcenCnt[1] + mcenCnt[2] + mcenCnt[3] + mcenCnt[4], 0);

    // Bouncing BtnL: 1,0,1,0 then stable 1
    $display("[TB] phase: bounce");
    resetStats();
    p = edgeNo;
    for (int i = 0; i < 40; i++)
      applyStimulus((i < 4) ? ((i % 2 == 0) ? 5'b00010 : 5'b0) : ((i < 24) ? 5'b00010 : 5'b0), 4'b1010);
    checkEq("bounce_scen_count", scenCnt[BTN_L], 1);
    checkEq("bounce_scen_edge", scenFirst[BTN_L], p + 5 + D + 2);

    // BtnR held, dropped for two cycles, then held again
    $display("[TB] phase: release glitch");
    resetStats();
    p = edgeNo + 1;
    g = p + 20;
    for (int i = 0; i < 66; i++)
      applyStimulus((i == 18 || i == 19 || i >= 50) ? 5'b0 : 5'b00100, 4'b1010);
    checkEq("glitch_scen_count", scenCnt[BTN_R], 1);
    checkEq("glitch_dpb_held", dpbFall[BTN_R], p + 50 + D + 2);
    checkEq("glitch_repeat_restart", mcenAt[BTN_R][2], g + 2 + R);

    // BtnU and BtnD pressed together
    $display("[TB] phase: simultaneous");
    resetStats();
    p = edgeNo + 1;
    for (int i = 0; i < 28; i++)
      applyStimulus((i < 14) ? 5'b11000 : 5'b0, 4'b1010);
    checkEq("simul_u_edge", scenFirst[BTN_U], p + D + 2);
    checkEq("simul_d_edge", scenFirst[BTN_D], p + D + 2);
    checkEq("simul_any_count", anyCnt, 1);
    checkEq("simul_any_edge", anyFirst, p + D + 2);

    // Asynchronous reset in the middle of a hold, button kept pressed
    $display("[TB] phase: async reset");
    resetStats();
    for (int i = 0; i < 12; i++) applyStimulus(5'b00001, 4'b1010);
    #2;
    Reset = 1'b0;
    #1;
    checkEq("arst_dpb", 32'(bus.Btn_DPB), 0);
    checkEq("arst_scen", 32'(bus.Btn_SCEN), 0);
    checkEq("arst_mcen", 32'(bus.Btn_MCEN), 0);
    checkEq("arst_sw", 32'(bus.Sw_sync), 0);
    checkEq("arst_any", 32'(bus.Any_SCEN), 0);
    modelReset();
    applyStimulus(5'b00001, 4'b1010);
    applyStimulus(5'b00001, 4'b1010);
    Reset = 1'b1;
    resetStats();
    p = edgeNo + 1;
    for (int i = 0; i < 12; i++) applyStimulus(5'b00001, 4'b1010);
    checkEq("arst_rearm_count", scenCnt[BTN_C], 1);
    checkEq("arst_rearm_edge", scenFirst[BTN_C], p + D + 2);
    for (int i = 0; i < 16; i++) applyStimulus(5'b0, 4'b1010);

    // Randomized soak: frequent toggling first, then longer holds
    $display("[TB] phase: random");
    cur = '0;
    swCur = 4'b1010;
    for (int i = 0; i < 500; i++) begin
      for (int b = 0; b < 5; b++)
        if ($urandom_range(0, (i < 200) ? 5 : 19) == 0) cur[b] = ~cur[b];
      if ($urandom_range(0, 15) == 0) swCur = 4'($urandom_range(0, 15));
      applyStimulus(cur, swCur);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
